// File: rtl/call_stack.sv
// rtl/call_stack.sv - bounded LIFO for the recursive-evaluation datapath
//
// Holds saved flag, argument n and partial result words across recursive calls.
// The stack reports full/empty status and its occupancy, and raises sticky
// overflow/underflow flags so the controller can detect recursion that is too deep.
//
// Optional feature macro: CALL_STACK_HWM_EN adds the hwm high-water-mark output.
//
// Ports:
//   clk       rising-edge system clock
//   rst_n     synchronous active-low reset (sp and error flags only; memory kept)
//   push      write din onto the top of the stack
//   pop       remove the top entry
//   din       data to push (WIDTH bits)
//   dout      show-ahead top of stack, 0 when empty
//   clr_err   clear the sticky error flags (a same-cycle error event wins)
//   empty     count == 0
//   full      count == DEPTH
//   count     number of valid entries, 0..DEPTH (AW+1 bits)
//   overflow  sticky: a push was rejected while full
//   underflow sticky: a pop was rejected while empty
//   hwm       (CALL_STACK_HWM_EN only) highest count seen since reset

module call_stack #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             clr_err,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
`ifdef CALL_STACK_HWM_EN
    ,
    output logic [AW:0]      hwm
`endif
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] SP_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] SP_ONE  = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0]   sp;
    logic [AW:0]   sp_nxt;
    logic [AW:0]   sp_m1;
    logic          we;
    logic [AW-1:0] waddr;
    logic          ovf_set;
    logic          udf_set;

    assign sp_m1 = sp - SP_ONE;
    assign empty = (sp == '0);
    assign full  = (sp == SP_FULL);
    assign count = sp;

    // Show-ahead read; depends on state only, so push/pop never reach dout
    // combinationally.
    assign dout = empty ? '0 : mem[sp_m1[AW-1:0]];

    // Operation decode. Rejected operations leave sp and the memory untouched,
    // so sp never wraps.
    always_comb begin
        sp_nxt  = sp;
        we      = 1'b0;
        waddr   = sp[AW-1:0];
        ovf_set = 1'b0;
        udf_set = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (!full) begin
                    we     = 1'b1;
                    waddr  = sp[AW-1:0];
                    sp_nxt = sp + SP_ONE;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    sp_nxt = sp_m1;
                end else begin
                    udf_set = 1'b1;
                end
            end
            2'b11: begin
                if (!empty) begin
                    // Replace the top in place; this also works when full.
                    we    = 1'b1;
                    waddr = sp_m1[AW-1:0];
                end else begin
                    // The push half still happens; only the pop is rejected.
                    we      = 1'b1;
                    waddr   = '0;
                    sp_nxt  = SP_ONE;
                    udf_set = 1'b1;
                end
            end
            default: begin
                sp_nxt = sp;
            end
        endcase
    end

    // Storage is deliberately not reset, so it can map to distributed RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp <= sp_nxt;
            // Setting takes precedence over clr_err in the same cycle.
            overflow  <= ovf_set | (overflow  & ~clr_err);
            underflow <= udf_set | (underflow & ~clr_err);
        end
    end

`ifdef CALL_STACK_HWM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hwm <= '0;
        end else if (sp_nxt > hwm) begin
            hwm <= sp_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_call_stack.sv
// tb/tb_call_stack.sv - scoreboard testbench for call_stack

module tb_call_stack;

    localparam int WIDTH = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic             clk;
    logic             rst_n;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             clr_err;
    logic             empty;
    logic             full;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;
`ifdef CALL_STACK_HWM_EN
    logic [AW:0]      hwm;
`endif

    call_stack #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .dout      (dout),
        .clr_err   (clr_err),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef CALL_STACK_HWM_EN
        ,
        .hwm       (hwm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dout;
        int         count;
        bit         empty;
        bit         full;
        bit         ovf;
        bit         udf;
        int         hwm;
        string      tag;
    } exp_t;

    exp_t sbq[$];

    // Reference model: a plain queue used as a stack.
    logic [7:0] model_q[$];
    bit         m_ovf;
    bit         m_udf;
    int         m_hwm;

    int n_checks;
    int n_fail;

    task automatic model_update(input bit p, input bit o, input logic [7:0] d,
                                input bit c, input bit r, input string tag);
        exp_t e;
        if (r) begin
            model_q.delete();
            m_ovf = 0;
            m_udf = 0;
            m_hwm = 0;
        end else begin
            if (c) begin
                m_ovf = 0;
                m_udf = 0;
            end
            if (p && o) begin
                if (model_q.size() > 0) begin
                    model_q[model_q.size()-1] = d;
                end else begin
                    model_q.push_back(d);
                    m_udf = 1;
                end
            end else if (p) begin
                if (model_q.size() < DEPTH) model_q.push_back(d);
                else m_ovf = 1;
            end else if (o) begin
                if (model_q.size() > 0) void'(model_q.pop_back());
                else m_udf = 1;
            end
            if (model_q.size() > m_hwm) m_hwm = model_q.size();
        end
        e.count = model_q.size();
        e.empty = (model_q.size() == 0);
        e.full  = (model_q.size() == DEPTH);
        e.dout  = (model_q.size() > 0) ? model_q[model_q.size()-1] : 8'h00;
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        e.hwm   = m_hwm;
        e.tag   = tag;
        sbq.push_back(e);
    endtask

    task automatic step(input bit p, input bit o, input logic [7:0] d,
                        input bit c, input bit r, input string tag);
        @(negedge clk);
        #1;
        push    = p;
        pop     = o;
        din     = d;
        clr_err = c;
        rst_n   = !r;
        @(posedge clk);
        #1;
        model_update(p, o, d, c, r, tag);
    endtask

    task automatic chk(input string name, input string tag, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0d required=%0d at %0t", tag, name, act, exp_v, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle once an expectation exists.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("dout",      e.tag, int'(dout),      int'(e.dout));
                chk("count",     e.tag, int'(count),     e.count);
                chk("empty",     e.tag, int'(empty),     int'(e.empty));
                chk("full",      e.tag, int'(full),      int'(e.full));
                chk("overflow",  e.tag, int'(overflow),  int'(e.ovf));
                chk("underflow", e.tag, int'(underflow), int'(e.udf));
`ifdef CALL_STACK_HWM_EN
                chk("hwm",       e.tag, int'(hwm),       e.hwm);
`endif
            end
        end
    end

    initial begin
        int phase_push;
        int wait_cyc;
        n_checks = 0;
        n_fail   = 0;
        m_ovf    = 0;
        m_udf    = 0;
        m_hwm    = 0;
        rst_n    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        din      = '0;
        clr_err  = 1'b0;

        step(0, 0, 8'h00, 0, 1, "reset");
        step(1, 0, 8'h33, 1, 1, "reset_prio");

        // Basic push/pop
        step(1, 0, 8'h05, 0, 0, "push05");
        step(1, 0, 8'h03, 0, 0, "push03");
        step(1, 0, 8'h07, 0, 0, "push07");
        step(0, 1, 8'h00, 0, 0, "pop1");

        // Fill, overflow, drain
        step(0, 0, 8'h00, 0, 1, "reset2");
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i), 0, 0, "fill");
        step(1, 0, 8'hAA, 0, 0, "overflow");
        step(1, 1, 8'h5C, 0, 0, "replace_full");
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, 0, 0, "drain");

        // Underflow and clr_err priority
        step(0, 1, 8'h00, 0, 0, "underflow");
        step(0, 0, 8'h00, 1, 0, "clr");
        step(0, 1, 8'h00, 1, 0, "clr_vs_set");
        step(0, 0, 8'h00, 1, 0, "clr2");

        // Simultaneous push+pop
        step(1, 0, 8'h01, 0, 0, "push01");
        step(1, 0, 8'h02, 0, 0, "push02");
        step(1, 1, 8'h09, 0, 0, "replace");
        step(0, 1, 8'h00, 0, 0, "pop_below");
        step(0, 1, 8'h00, 0, 0, "pop_last");
        step(1, 1, 8'h04, 0, 0, "pp_empty");

        // Reset mid-sequence with a push
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i), 0, 0, "push5");
        step(1, 0, 8'hEE, 0, 1, "reset_push");
        step(0, 0, 8'h00, 0, 0, "after_reset");

        // High-water mark sequence
        for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h60 + i), 0, 0, "hwm_push6");
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, 0, "hwm_pop4");
        for (int i = 0; i < 2; i++) step(1, 0, 8'(8'h70 + i), 0, 0, "hwm_push2");
        step(0, 0, 8'h00, 0, 1, "hwm_reset");

        // Randomized traffic with alternating push-heavy / pop-heavy phases
        phase_push = 1;
        for (int n = 0; n < 3000; n++) begin
            bit p;
            bit o;
            bit c;
            bit r;
            if (n % 60 == 0) phase_push = !phase_push;
            p = phase_push ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            o = phase_push ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 299) == 0);
            step(p, o, 8'($urandom), c, r, "random");
        end

        // Let the monitor drain, bounded.
        wait_cyc = 0;
        while (sbq.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sbq.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain actual=%0d pending required=0", sbq.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- LIFO storage for the recursive-evaluation datapath. It holds saved flag, argument n and partial result values across recursive calls.
- Consumes the datapath's din/push/pop and returns top-of-stack on dout.
- Replaces the bare stack model with a bounded, checked stack:
  - full/empty status
  - occupancy count
  - sticky overflow/underflow error flags, so the main controller can detect a recursion depth that exceeds capacity.

Parameters:
- WIDTH, 8: data word width; matches the 8-bit datapath registers.
- AW, 4: address width; DEPTH = 2**AW entries (16 by default).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- push  in  1  write din onto top of stack this cycle
- pop  in  1  remove top entry this cycle
- din  in  WIDTH  data to push
- dout  out  WIDTH  current top-of-stack (show-ahead)
- clr_err  in  1  clear sticky error flags
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  AW+1  number of valid entries, 0..DEPTH
- overflow  out  1  sticky: push rejected while full
- underflow  out  1  sticky: pop rejected while empty

Behaviour:
- State: stack pointer sp (AW+1 bits, equal to count) and memory mem[0..DEPTH-1]. Memory is not reset.
- Reset (rst_n low at a rising edge): sp=0, overflow=0, underflow=0.
  - Resulting outputs: empty=1, full=0, count=0, dout=0.
  - Reset takes priority over push/pop/clr_err in the same cycle.
  - Reset mid-sequence discards all contents.
- dout is combinational from state: mem[sp-1] when sp>0, else 0.
  - Zero-latency peek: the controller may sample dout and assert pop in the same cycle to load it into a register.
  - dout changes only after a clock edge, never directly from push/pop.
- Operations per edge, decided on {push,pop} and sp:
  - 00: no change.
  - 10, not full: mem[sp]<=din; sp<=sp+1. New top is visible on dout the next cycle.
  - 10, full: ignored; overflow<=1; contents and sp unchanged.
  - 01, not empty: sp<=sp-1; the entry is not cleared.
  - 01, empty: ignored; underflow<=1.
  - 11, not empty (including full): replace top, mem[sp-1]<=din; sp unchanged; no error.
  - 11, empty: push performed (mem[0]<=din, sp<=1); underflow<=1 for the rejected pop.
- clr_err=1: overflow<=0 and underflow<=0 on that edge.
  - If an error event occurs in the same cycle, the set wins (flag stays 1).
- full = (sp==DEPTH); empty = (sp==0). Both are combinational from sp.
- No wrap-around: sp saturates within 0..DEPTH; rejected operations never corrupt stored entries.
- Memory write port: single write per cycle; read is asynchronous. Implementable as distributed RAM or a register array.

Optional Feature:
- Macro: CALL_STACK_HWM_EN.
- Defined:
  - Adds output port hwm [AW:0], the high-water mark of sp since the last reset.
  - Update rule: on each edge, if the next sp > hwm, then hwm <= next sp.
  - Reset value 0; not cleared by clr_err.
  - Used to size DEPTH for the largest supported n.
- Not defined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset, then push 8'h05, 8'h03, 8'h07 on three consecutive cycles -> count=3, dout=8'h07; pop one cycle -> dout=8'h03, count=2.
- DEPTH=16: push 0..15 -> full=1, count=16; push 8'hAA -> overflow=1, count=16, dout=8'h0F; pop 16 times -> dout sequence 15..0, then empty=1, dout=0.
- From empty, pop -> underflow=1, count=0; clr_err -> underflow=0; clr_err plus a pop on empty in the same cycle -> underflow stays 1.
- Stack holding {8'h01, 8'h02}: push+pop with din=8'h09 -> count=2, dout=8'h09; below it still 8'h01 after a pop. Empty stack, push+pop din=8'h04 -> count=1, dout=8'h04, underflow=1.
- Push 5 entries, assert rst_n=0 with push=1 in the same cycle -> count=0, empty=1, dout=0, flags 0; no entry was added.
- With CALL_STACK_HWM_EN: push 6, pop 4, push 2 -> hwm=6, count=4; after reset hwm=0.
